// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding,
// default register-index width and the enable/flush bundle used by the core top level.
package pipeline_ctrl_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pc_sel_branch;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(9'b1_1111_0000);
  localparam pipe_ctrl_t CTRL_HOLD   = pipe_ctrl_t'(9'b0_0000_0000);
  localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(9'b1_1111_1111);
  localparam pipe_ctrl_t CTRL_BUBBLE = pipe_ctrl_t'(9'b0_0111_0100);

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // count up on inc, stick at all-ones
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller: combinational enables/flushes for PC and pipeline
// registers, RUN/WAIT/ERR memory-wait FSM with watchdog, stall/flush counters.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_sel_branch,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_nxt;
  logic        r_mem_timeout;
  logic        w_trip;
  logic        w_memwait;
  logic        w_loaduse;
  pipe_ctrl_t  w_ctrl;

  assign w_memwait = mem_req & ~mem_ready;
  // x0 never carries a dependency, so rd==0 cannot stall
  assign w_loaduse = id_ex_memread && (id_ex_rd != '0) &&
                     ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

  // hazard priority and next-state decode; a completed wait is evaluated like RUN
  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_trip      = 1'b0;
    case (r_state)
      ST_RUN, ST_WAIT: begin
        if (w_memwait) begin
          w_ctrl     = CTRL_HOLD;
          w_wait_nxt = (r_state == ST_RUN) ? 16'd1 : (r_wait_cnt + 16'd1);
          if (w_wait_nxt >= 16'(WAIT_TIMEOUT)) begin
            w_state_nxt = ST_ERR;
            w_trip      = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 16'd0;
          if (branch_taken) begin
            w_ctrl = CTRL_BRANCH;
          end else if (w_loaduse) begin
            w_ctrl = CTRL_BUBBLE;
          end else begin
            w_ctrl = CTRL_RUN;
          end
        end
      end
      ST_ERR: begin
        w_ctrl      = CTRL_HOLD;
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_ctrl      = CTRL_HOLD;
        w_state_nxt = ST_ERR;
        w_trip      = 1'b1;
      end
    endcase
  end

  // state, wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= r_mem_timeout | w_trip;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (~w_ctrl.pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_ctrl.pc_sel_branch),
    .cnt (flush_cnt)
  );

  assign pc_en         = w_ctrl.pc_en;
  assign if_id_en      = w_ctrl.if_id_en;
  assign id_ex_en      = w_ctrl.id_ex_en;
  assign ex_mem_en     = w_ctrl.ex_mem_en;
  assign mem_wb_en     = w_ctrl.mem_wb_en;
  assign if_id_flush   = w_ctrl.if_id_flush;
  assign id_ex_flush   = w_ctrl.id_ex_flush;
  assign ex_mem_flush  = w_ctrl.ex_mem_flush;
  assign pc_sel_branch = w_ctrl.pc_sel_branch;
  assign mem_timeout   = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: table of vectors through a scoreboard queue on the
// default build, plus watchdog/saturation sequences on a WAIT_TIMEOUT=3, CNT_W=4 build.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst2;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs2, id_ex_memread, branch_taken, mem_req, mem_ready;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2;
  logic        if_id_flush2, id_ex_flush2, ex_mem_flush2, pc_sel_branch2, mem_timeout2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  logic [8:0] bund, bund2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] E_RUN = 9'b1_1111_0000;
  localparam logic [8:0] E_HLD = 9'b0_0000_0000;
  localparam logic [8:0] E_BR  = 9'b1_1111_1111;
  localparam logic [8:0] E_LU  = 9'b0_0111_0100;

  always #5 clk = ~clk;

  pipeline_stall_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .WAIT_TIMEOUT(3)) u_dut2 (
    .clk(clk), .rst(rst2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en2), .if_id_en(if_id_en2),
    .id_ex_en(id_ex_en2), .ex_mem_en(ex_mem_en2), .mem_wb_en(mem_wb_en2),
    .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2), .ex_mem_flush(ex_mem_flush2),
    .pc_sel_branch(pc_sel_branch2), .mem_timeout(mem_timeout2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  assign bund  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch};
  assign bund2 = {pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2,
                  if_id_flush2, id_ex_flush2, ex_mem_flush2, pc_sel_branch2};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, ex_rd;
    logic       uses_rs2, memread, br, mreq, mrdy;
    logic [8:0] exp_ctrl;
    int         exp_stall, exp_flush;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] ctrl;
    int         stall, flush;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic mq, input logic my);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; id_ex_memread = mr;
    id_ex_rd = rd; branch_taken = br; mem_req = mq; mem_ready = my;
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u2, input logic mr, input logic [4:0] rd,
                              input logic br, input logic mq, input logic my,
                              input logic [8:0] e, input int es, input int ef);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.uses_rs2 = u2; v.memread = mr; v.ex_rd = rd;
    v.br = br; v.mreq = mq; v.mrdy = my; v.exp_ctrl = e; v.exp_stall = es; v.exp_flush = ef;
    return v;
  endfunction

  initial begin
    exp_t e;
    logic [31:0] exp_st;

    vecs[0]  = mk("idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, 0, 0);
    vecs[1]  = mk("loaduse_rs1", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU,  1, 0);
    vecs[2]  = mk("rd_x0",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, 1, 0);
    vecs[3]  = mk("rs2_unused",  5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN, 1, 0);
    vecs[4]  = mk("loaduse_rs2", 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU,  2, 0);
    vecs[5]  = mk("no_memread",  5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN, 2, 0);
    vecs[6]  = mk("br_over_lu",  5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_BR,  2, 1);
    vecs[7]  = mk("memwait1",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_HLD, 3, 1);
    vecs[8]  = mk("memwait2",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_HLD, 4, 1);
    vecs[9]  = mk("memwait3",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_HLD, 5, 1);
    vecs[10] = mk("memwait4",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_HLD, 6, 1);
    vecs[11] = mk("ready_br",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_BR,  6, 2);
    vecs[12] = mk("mem_hit",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, 6, 2);
    vecs[13] = mk("back_idle",   5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, E_RUN, 6, 2);

    rst = 1'b1; rst2 = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rs2, vecs[i].memread,
            vecs[i].ex_rd, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
      e.name = vecs[i].name; e.ctrl = vecs[i].exp_ctrl;
      e.stall = vecs[i].exp_stall; e.flush = vecs[i].exp_flush;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, "_ctrl"}, {23'd0, bund}, {23'd0, e.ctrl});
      @(posedge clk);
      #1;
      chk({e.name, "_stall_cnt"}, stall_cnt, e.stall);
      chk({e.name, "_flush_cnt"}, flush_cnt, e.flush);
      chk({e.name, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
    end

    // second build: watchdog trip at 3 waits, then saturation of the 4-bit stall counter
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst2 = 1'b0;
    exp_st = 32'd0;
    for (int k = 1; k <= 25; k++) begin
      if (k <= 5) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      else        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("wd_ctrl_%0d", k), {23'd0, bund2}, {23'd0, E_HLD});
      @(posedge clk);
      #1;
      exp_st = (exp_st == 32'd15) ? 32'd15 : exp_st + 32'd1;
      chk($sformatf("wd_timeout_%0d", k), {31'd0, mem_timeout2}, (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("wd_stall_cnt_%0d", k), {28'd0, stall_cnt2}, exp_st);
    end
    chk("wd_flush_cnt", {28'd0, flush_cnt2}, 32'd0);

    // reset out of ERR wins over a live memory wait
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    rst2 = 1'b1;
    @(posedge clk);
    #1 rst2 = 1'b0;
    chk("err_rst_timeout", {31'd0, mem_timeout2}, 32'd0);
    chk("err_rst_stall_cnt", {28'd0, stall_cnt2}, 32'd0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("err_rst_run_ctrl", {23'd0, bund2}, {23'd0, E_RUN});
    @(posedge clk);
    #1;
    chk("err_rst_stall_hold", {28'd0, stall_cnt2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
